hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Hazard and stall controller for the 5-stage MIPS pipeline.
- Mirrors the ID/EX, EX/MEM and MEM/WB destination records in a shadow pipeline. Compares them against the operands being decoded in ID.
- Drives stall, bubble, flush and freeze controls that the forwarding logic cannot resolve: load-use, WB-to-ID read without register-file bypass, taken-branch squash, and multi-cycle data-memory wait.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
- RF_BYPASS, 1: 1 means the register file returns write data on a same-cycle read; 0 means a WB-to-ID match must stall.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  5 each  ID source registers.
- id_uses_rs, id_uses_rt  in  1 each  instruction reads that source.
- id_rd  in  5  ID destination, taken after the RegDst mux.
- id_regwrite, id_memread  in  1 each  ID control bits.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- mem_req  in  1  MEM stage is issuing a load or store this cycle.
- dmem_ready  in  1  data memory is completing the access this cycle.
- stall_pc, stall_ifid  out  1 each  hold PC and IF/ID.
- bubble_idex  out  1  zero ID/EX control bits.
- flush_ifid  out  1  replace IF/ID with a NOP.
- freeze_back  out  1  hold ID/EX, EX/MEM and MEM/WB.
- busy_state  out  2  FSM state, for debug.
- stall_cnt, flush_cnt  out  CNT_W each  saturating counters.

Behaviour:
- Shadow slots ex, mem and wb each hold {v, rd, wr, ld}. A slot writes only if v & wr & (rd != 0).
- Slot advance, when freeze_back = 0:
  - wb <- mem; mem <- ex.
  - ex <- the ID record when id_valid & !bubble_idex; otherwise an invalid slot.
- When freeze_back = 1, all slots hold.
- srcmatch(s) = (id_uses_rs & id_rs == s.rd) | (id_uses_rt & id_rt == s.rd), evaluated only for slots that write.
- lu_hz = id_valid & ex.ld & srcmatch(ex).
- wb_hz = (RF_BYPASS == 0) & id_valid & srcmatch(wb).
- mw = mem_req & !dmem_ready.
- FSM states: RUN = 0, MEM_WAIT = 1, HAZ = 2.
  - RUN -> MEM_WAIT when mw.
  - MEM_WAIT -> RUN on the first cycle with dmem_ready = 1.
  - RUN -> HAZ when (lu_hz | wb_hz) & !ex_branch_taken.
  - HAZ -> RUN on the next cycle. Each hazard resolves in exactly one stall cycle, after which it is re-evaluated.
- Outputs are combinational from the FSM state and the current inputs.
- Priority, highest first:
  1. mw, in any state: stall_pc = stall_ifid = freeze_back = 1; bubble_idex = flush_ifid = 0. A branch pending in EX is not acted on until the freeze ends; its flush is applied in the first unfrozen cycle.
  2. ex_branch_taken: flush_ifid = bubble_idex = 1; stalls = 0. The flush overrides any load-use or WB hazard, because the hazarding instruction is squashed.
  3. lu_hz | wb_hz: stall_pc = stall_ifid = bubble_idex = 1.
  4. Otherwise all controls are 0.
- Load-use costs exactly 1 bubble. After the bubble the load sits in mem and the forwarding unit supplies the value.
- Counters:
  - stall_cnt increments on every cycle with stall_pc = 1.
  - flush_cnt increments on every cycle with flush_ifid = 1.
  - Both saturate at all-ones.
- Reset, asynchronous and active-high:
  - All slots invalid, FSM = RUN, counters = 0.
  - All control outputs 0, busy_state = 0.
  - Reset asserted mid-freeze or mid-stall aborts it immediately, with no residual bubble after release.
- Register $0 never creates a hazard.
- id_valid = 0 never stalls.

Decomposition:
- Package hazard_pkg holds:
  - the state encodings S_RUN, S_MEM_WAIT, S_HAZ;
  - the slot record type {v, rd[4:0], wr, ld};
  - the function src_match(rs, rt, use_rs, use_rt, slot).
- One sub-module, hazard_shadow_pipe, holds the three slots and their advance, hold and bubble rules.
- The FSM, priority logic and counters stay in the top module.

Test Plan:
- Load-use: lw $8 in EX (ex.ld, rd = 8) and ID add reads rs = 8 -> exactly 1 cycle of stall_pc = stall_ifid = bubble_idex = 1; next cycle all controls 0; stall_cnt = 1.
- Branch beats hazard: the load-use condition above plus ex_branch_taken = 1 in the same cycle -> flush_ifid = bubble_idex = 1, stall_pc = 0; flush_cnt = 1, stall_cnt = 0.
- Memory wait: mem_req = 1 with dmem_ready low for 3 cycles -> freeze_back = stall_pc = 1 for 3 cycles, busy_state = 1, slots unchanged; the 4th cycle (ready) releases to RUN.
- RF_BYPASS = 0: wb slot writes $5 and ID reads rt = 5 -> 1 stall cycle. With RF_BYPASS = 1 the same case -> no stall.
- Register $0 / invalid ID: load to $0 with ID reading $0, or id_valid = 0 with a matching register -> no stall.
- Reset mid-wait: assert rst during MEM_WAIT -> outputs 0 and busy_state = 0 immediately; counters 0; slots invalid after release.
- Saturation: with CNT_W = 4, run 20 stall cycles -> stall_cnt holds 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard scoreboard: FSM encoding,
// shadow slot record and the source-operand match used against each slot.
package hazard_pkg;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HAZ      = 2'd2
    } state_e;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    // $0 is hardwired, so a slot targeting it never produces a value anyone waits on.
    function automatic logic slot_writes(input slot_t s);
        return s.v & s.wr & (s.rd != 5'd0);
    endfunction

    function automatic logic src_match(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic use_rs, input logic use_rt,
                                       input slot_t slot);
        return slot_writes(slot) &
               ((use_rs & (rs == slot.rd)) | (use_rt & (rt == slot.rd)));
    endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Shadow copy of the ID/EX, EX/MEM and MEM/WB destination records. Advances with
// the real pipeline, holds while the back end is frozen, takes a bubble on stall/flush.
module hazard_shadow_pipe
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       freeze,
    input  logic       bubble,
    input  logic       id_valid,
    input  logic [4:0] id_rd,
    input  logic       id_regwrite,
    input  logic       id_memread,
    output slot_t      ex_slot,
    output slot_t      wb_slot
);

    slot_t ex_q, mem_q, wb_q;
    slot_t id_slot;

    assign id_slot = '{v: 1'b1, rd: id_rd, wr: id_regwrite, ld: id_memread};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= SLOT_EMPTY;
            mem_q <= SLOT_EMPTY;
            wb_q  <= SLOT_EMPTY;
        end else if (!freeze) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= (id_valid & !bubble) ? id_slot : SLOT_EMPTY;
        end
    end

    assign ex_slot = ex_q;
    assign wb_slot = wb_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/bubble/flush/freeze controller for the 5-stage pipeline, covering the cases
// forwarding cannot: load-use, WB read without RF bypass, taken branch, slow dmem.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter bit          RF_BYPASS = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic             freeze_back,
    output logic [1:0]       busy_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    slot_t            ex_slot, wb_slot;
    logic             lu_hz, wb_hz, mw;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    hazard_shadow_pipe u_shadow (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze_back),
        .bubble      (bubble_idex),
        .id_valid    (id_valid),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .ex_slot     (ex_slot),
        .wb_slot     (wb_slot)
    );

    assign lu_hz = id_valid & ex_slot.ld &
                   src_match(id_rs, id_rt, id_uses_rs, id_uses_rt, ex_slot);
    assign wb_hz = (RF_BYPASS == 1'b0) & id_valid &
                   src_match(id_rs, id_rt, id_uses_rs, id_uses_rt, wb_slot);
    assign mw    = mem_req & !dmem_ready;

    // Outputs are gated by rst so an in-flight freeze or stall drops the moment reset rises.
    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        freeze_back = 1'b0;
        if (rst) begin
            stall_pc = 1'b0;
        end else if (mw) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            freeze_back = 1'b1;
        end else if (ex_branch_taken) begin
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
        end else if (lu_hz | wb_hz) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (mw) begin
                    state_d = S_MEM_WAIT;
                end else if ((lu_hz | wb_hz) & !ex_branch_taken) begin
                    state_d = S_HAZ;
                end
            end
            S_MEM_WAIT: if (dmem_ready) state_d = S_RUN;
            S_HAZ:      state_d = S_RUN;
            default:    state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall_pc && (stall_cnt_q != CNT_MAX)) stall_cnt_q <= stall_cnt_q + CNT_ONE;
            if (flush_ifid && (flush_cnt_q != CNT_MAX)) flush_cnt_q <= flush_cnt_q + CNT_ONE;
        end
    end

    assign busy_state = state_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule
